regs_wb_arbiter: RTL and testbench
==================================

// Module: regs_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (L_S/Wt_addr/Wt_data) between N write-back sources
//  (ALU, load unit, mul/div) of the multi-cycle CPU.
//  - Each source has a valid/ready handshake and a one-entry holding buffer.
//  - A round-robin arbiter drains the buffers into a registered write stage.
//  - Pending-write flags for both read ports let the control FSM stall on RAW hazards.
// PARAMETERS
//  N_REQ  3   number of write-back sources (2..8)
//  DW     32  data width
//  AW     5   register address width
// PORTS
//  clk        in   1         clock, all state updates on posedge
//  rst        in   1         synchronous, active-low reset; sampled on posedge clk
//  req_valid  in   N_REQ     source i presents a write
//  req_addr   in   N_REQ*AW  dest reg of source i, slice [i*AW +: AW]
//  req_data   in   N_REQ*DW  data of source i, slice [i*DW +: DW]
//  req_ready  out  N_REQ     source i may hand over a write this cycle
//  R_addr_A   in   AW        read-port A address (hazard query)
//  R_addr_B   in   AW        read-port B address (hazard query)
//  pend_A     out  1         a write to R_addr_A is buffered or staged
//  pend_B     out  1         a write to R_addr_B is buffered or staged
//  L_S        out  1         register-file write enable, registered
//  Wt_addr    out  AW        register-file write address, registered
//  Wt_data    out  DW        register-file write data, registered
// BEHAVIOUR
//  Reset (rst==0 at posedge)
//   - All buffers empty; rr pointer = 0; L_S=0, Wt_addr=0, Wt_data=0.
//   - req_ready and pend_A/B read 0 while rst==0.
//   - Reset mid-operation discards buffered writes that have not yet reached the staged stage.
//  Handshake
//   - Transfer when req_valid[i] && req_ready[i] at posedge.
//   - req_ready[i] = !buf_v[i] || grant[i] (combinational); never depends on req_valid[i].
//   - Writes with addr==0 are accepted and dropped: they never fill the buffer and never assert L_S.
//  Arbitration
//   - Each cycle, grant = first buf_v[j] searching j = ptr, ptr+1, ... modulo N_REQ; one-hot or zero.
//   - Granted buffer -> write stage at the same posedge.
//   - L_S=1 for exactly one cycle per granted write.
//   - ptr <= (granted index + 1) mod N_REQ; ptr is unchanged when there is no grant.
//   - Granted buffer may refill in the same cycle (accept and grant simultaneous).
//  Latency and throughput
//   - Accept at edge k -> L_S/Wt_* valid in the cycle after edge k+1 -> register written at edge k+2.
//   - Sustained throughput is one write per cycle total.
//   - No starvation: a buffered write waits at most N_REQ-1 grants.
//  Ordering
//   - Writes from one source retire in order.
//   - Writes to the same reg from different sources retire in grant order. Avoiding WAW is the
//     control FSM's job.
//  Hazard
//   - pend_A = (R_addr_A!=0) && (any buf_v[i] with buf_addr[i]==R_addr_A, or L_S && Wt_addr==R_addr_A).
//   - pend_B is the same for R_addr_B.
//   - Both are combinational from state and address only.
// CONFIGURATION
//  REGS_WB_BYPASS_EN defined
//   - Adds outputs byp_A_v/byp_A_data and byp_B_v/byp_B_data (DW).
//   - byp_X_v = L_S && Wt_addr==R_addr_X && R_addr_X!=0; byp_X_data = Wt_data.
//   - pend_X excludes the staged write, so the FSM reads staged data without stalling.
//  Undefined
//   - No bypass ports; pend_X includes the staged write as specified above.
// STRUCTURE
//  Package regs_pkg
//   - REG_AW=5, REG_DW=32, WB_N_REQ=3.
//   - Source indices WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_MDU=2.
//   - typedef wb_req_t {addr, data}.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; output one-hot grant[N] plus grant index.
//   Combinational only; ptr register lives in the parent.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, L_S=0, Wt_addr=0, Wt_data=0;
//     no write appears after release until fresh handshakes.
//  2. Single write: src1 writes r5=0xDEADBEEF at edge k -> L_S=1, Wt_addr=5, Wt_data=0xDEADBEEF
//     for exactly one cycle after edge k+1; pend_A=1 (R_addr_A=5) until that L_S cycle ends.
//  3. Contention: all three sources valid every cycle (r1/r2/r3) -> grants rotate 0,1,2,0,...;
//     one L_S per cycle; no source waits more than 2 grants.
//  4. r0 drop: src0 writes r0=0x1234 -> accepted (req_ready=1); L_S never asserts; pend_A=0 for R_addr_A=0.
//  5. Mid-op reset: fill all 3 buffers, pull rst=0 for one edge -> buffers cleared; no L_S in the
//     following cycles; ptr restarts at 0.
//  6. REGS_WB_BYPASS_EN: staged write r7=0x55, R_addr_B=7 -> byp_B_v=1, byp_B_data=0x55, pend_B=0;
//     without the macro -> pend_B=1.

Source files
------------

// File: rtl/regs_wb_arbiter_pkg.sv
// regs_pkg: shared widths, source indices and write-back request type for regs_wb_arbiter.
package regs_pkg;
    localparam int REG_AW     = 5;
    localparam int REG_DW     = 32;
    localparam int WB_N_REQ   = 3;
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MEM = 1;
    localparam int WB_SRC_MDU = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regs_wb_arbiter_if.sv
// regs_wb_arbiter_if: write-back requests, hazard queries and register-file write port.
// The byp_* signals exist only when REGS_WB_BYPASS_EN is defined.
interface regs_wb_arbiter_if import regs_pkg::*; #(
    parameter int N_REQ = WB_N_REQ,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [AW-1:0]       R_addr_A;
    logic [AW-1:0]       R_addr_B;
    logic                pend_A;
    logic                pend_B;
    logic                L_S;
    logic [AW-1:0]       Wt_addr;
    logic [DW-1:0]       Wt_data;
`ifdef REGS_WB_BYPASS_EN
    logic                byp_A_v;
    logic [DW-1:0]       byp_A_data;
    logic                byp_B_v;
    logic [DW-1:0]       byp_B_data;
`endif

    modport master (
        output req_valid, req_addr, req_data, R_addr_A, R_addr_B,
        input  req_ready, pend_A, pend_B, L_S, Wt_addr, Wt_data
`ifdef REGS_WB_BYPASS_EN
        , input byp_A_v, byp_A_data, byp_B_v, byp_B_data
`endif
    );

    modport slave (
        input  req_valid, req_addr, req_data, R_addr_A, R_addr_B,
        output req_ready, pend_A, pend_B, L_S, Wt_addr, Wt_data
`ifdef REGS_WB_BYPASS_EN
        , output byp_A_v, byp_A_data, byp_B_v, byp_B_data
`endif
    );
endinterface

// File: rtl/regs_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick searching from ptr_i upward, one-hot grant plus index.
module rr_arbiter import regs_pkg::*; #(
    parameter int  N  = WB_N_REQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] j;

    // scanning farthest-first lets the nearest requester overwrite the result
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: shares the register-file write port among N write-back sources, round-robin.
// Defining REGS_WB_BYPASS_EN adds staged-write forwarding ports and drops the staged write from pend_*.
module regs_wb_arbiter import regs_pkg::*; #(
    parameter int N_REQ = WB_N_REQ,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
) (
    input logic              clk,
    input logic              rst,
    regs_wb_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] buf_v_q, buf_v_d, grant, ready;
    logic [AW-1:0]    buf_addr_q [N_REQ];
    logic [AW-1:0]    buf_addr_d [N_REQ];
    logic [DW-1:0]    buf_data_q [N_REQ];
    logic [DW-1:0]    buf_data_d [N_REQ];
    logic [IW-1:0]    ptr_q, ptr_d, gnt_idx;
    logic             gnt_any, ls_q, ls_d;
    logic [AW-1:0]    wt_addr_q, wt_addr_d;
    logic [DW-1:0]    wt_data_q, wt_data_d;
    logic             hit_a, hit_b, stg_a, stg_b;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (buf_v_q),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    always_comb begin
        buf_v_d    = buf_v_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        ready      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready[i] = rst && (!buf_v_q[i] || grant[i]);
            if (grant[i]) buf_v_d[i] = 1'b0;
            // r0 writes complete the handshake but never occupy the buffer
            if (bus.req_valid[i] && ready[i] && bus.req_addr[i*AW +: AW] != '0) begin
                buf_v_d[i]    = 1'b1;
                buf_addr_d[i] = bus.req_addr[i*AW +: AW];
                buf_data_d[i] = bus.req_data[i*DW +: DW];
            end
        end
        ls_d      = gnt_any;
        wt_addr_d = gnt_any ? buf_addr_q[gnt_idx] : wt_addr_q;
        wt_data_d = gnt_any ? buf_data_q[gnt_idx] : wt_data_q;
        ptr_d     = !gnt_any ? ptr_q : (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_v_q   <= '0;
            ptr_q     <= '0;
            ls_q      <= 1'b0;
            wt_addr_q <= '0;
            wt_data_q <= '0;
        end else begin
            buf_v_q   <= buf_v_d;
            ptr_q     <= ptr_d;
            ls_q      <= ls_d;
            wt_addr_q <= wt_addr_d;
            wt_data_q <= wt_data_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            hit_a = hit_a | (buf_v_q[i] && buf_addr_q[i] == bus.R_addr_A);
            hit_b = hit_b | (buf_v_q[i] && buf_addr_q[i] == bus.R_addr_B);
        end
    end

    assign stg_a = ls_q && wt_addr_q == bus.R_addr_A;
    assign stg_b = ls_q && wt_addr_q == bus.R_addr_B;

`ifdef REGS_WB_BYPASS_EN
    // the staged write is forwarded to the reader instead of stalling it
    assign bus.pend_A     = rst && bus.R_addr_A != '0 && hit_a;
    assign bus.pend_B     = rst && bus.R_addr_B != '0 && hit_b;
    assign bus.byp_A_v    = stg_a && bus.R_addr_A != '0;
    assign bus.byp_B_v    = stg_b && bus.R_addr_B != '0;
    assign bus.byp_A_data = wt_data_q;
    assign bus.byp_B_data = wt_data_q;
`else
    assign bus.pend_A = rst && bus.R_addr_A != '0 && (hit_a || stg_a);
    assign bus.pend_B = rst && bus.R_addr_B != '0 && (hit_b || stg_b);
`endif

    assign bus.req_ready = ready;
    assign bus.L_S       = ls_q;
    assign bus.Wt_addr   = wt_addr_q;
    assign bus.Wt_data   = wt_data_q;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed and random stimulus checked against a cycle-level reference model.
module tb_regs_wb_arbiter;
    import regs_pkg::*;
    localparam int N  = WB_N_REQ;
    localparam int AW = REG_AW;
    localparam int DW = REG_DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    regs_wb_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus ();
    regs_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference: one slot per source, a rotating pointer and the staged write
    logic          m_v [N];
    logic [AW-1:0] m_a [N];
    logic [DW-1:0] m_d [N];
    int            m_ptr = 0;
    logic          m_ls = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic m_pend(logic [AW-1:0] r);
        if (!rst || r == '0) return 1'b0;
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_a[i] == r) return 1'b1;
`ifndef REGS_WB_BYPASS_EN
        if (m_ls && m_wa == r) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic drive(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic tick();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        g = pick();
        for (int i = 0; i < N; i++) er[i] = rst && (!m_v[i] || g == i);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("pend_A", 64'(bus.pend_A), 64'(m_pend(bus.R_addr_A)));
        chk("pend_B", 64'(bus.pend_B), 64'(m_pend(bus.R_addr_B)));
        chk("L_S", 64'(bus.L_S), 64'(m_ls));
        if (m_ls) begin
            chk("Wt_addr", 64'(bus.Wt_addr), 64'(m_wa));
            chk("Wt_data", 64'(bus.Wt_data), 64'(m_wd));
        end
`ifdef REGS_WB_BYPASS_EN
        chk("byp_A_v", 64'(bus.byp_A_v), 64'(m_ls && m_wa == bus.R_addr_A && bus.R_addr_A != '0));
        chk("byp_B_v", 64'(bus.byp_B_v), 64'(m_ls && m_wa == bus.R_addr_B && bus.R_addr_B != '0));
        if (m_ls) chk("byp_data", 64'(bus.byp_A_data), 64'(m_wd));
`endif
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_ptr = 0;
            m_ls  = 1'b0;
            m_wa  = '0;
            m_wd  = '0;
        end else begin
            m_ls = (g >= 0);
            if (g >= 0) begin
                m_wa     = m_a[g];
                m_wd     = m_d[g];
                m_v[g]   = 1'b0;
                m_ptr    = (g + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (bus.req_valid[i] && er[i] && bus.req_addr[i*AW +: AW] != '0) begin
                    m_v[i] = 1'b1;
                    m_a[i] = bus.req_addr[i*AW +: AW];
                    m_d[i] = bus.req_data[i*DW +: DW];
                end
        end
        #1;
    endtask

    task automatic idle(int n);
        bus.req_valid = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int prev;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0;
            m_a[i] = '0;
            m_d[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.R_addr_A  = '0;
        bus.R_addr_B  = '0;
        @(posedge clk);
        #1;

        // reset held with every source requesting
        for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
        tick();
        tick();
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_L_S", 64'(bus.L_S), 64'(0));
        chk("rst_Wt_addr", 64'(bus.Wt_addr), 64'(0));
        chk("rst_Wt_data", 64'(bus.Wt_data), 64'(0));
        rst = 1'b1;
        idle(3);

        // single write r5 from source 1
        bus.R_addr_A = AW'(5);
        drive(WB_SRC_MEM, 1'b1, AW'(5), 32'hDEADBEEF);
        tick();
        bus.req_valid = '0;
        chk("single_pend_buf", 64'(bus.pend_A), 64'(1));
        chk("single_ls_early", 64'(bus.L_S), 64'(0));
        tick();
        chk("single_ls", 64'(bus.L_S), 64'(1));
        chk("single_addr", 64'(bus.Wt_addr), 64'(5));
        chk("single_data", 64'(bus.Wt_data), 64'(32'hDEADBEEF));
        chk("single_pend_stg", 64'(bus.pend_A), 64'(1));
        tick();
        chk("single_ls_end", 64'(bus.L_S), 64'(0));
        chk("single_pend_end", 64'(bus.pend_A), 64'(0));
        idle(2);

        // contention: every source valid every cycle
        prev = -1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 1), DW'((i << 8) | c));
            tick();
            if (c >= 2) chk("cont_ls_every", 64'(bus.L_S), 64'(1));
            if (bus.L_S) begin
                if (prev > 0) chk("rr_rotate", 64'(bus.Wt_addr), 64'(prev % N + 1));
                prev = int'(bus.Wt_addr);
            end
        end
        idle(4);

        // r0 write is accepted and dropped
        bus.R_addr_A = '0;
        drive(WB_SRC_ALU, 1'b1, '0, 32'h1234);
        chk("r0_ready", 64'(bus.req_ready[0]), 64'(1));
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk("r0_no_ls", 64'(bus.L_S), 64'(0));
            chk("r0_no_pend", 64'(bus.pend_A), 64'(0));
            tick();
        end

        // mid-operation reset flushes buffered writes and the pointer
        for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 4), DW'(32'hC0 + i));
        tick();
        tick();
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_ls0", 64'(bus.L_S), 64'(0));
        tick();
        chk("midrst_ls1", 64'(bus.L_S), 64'(0));
        tick();
        chk("midrst_ls2", 64'(bus.L_S), 64'(0));
        for (int i = 0; i < N; i++) drive(i, 1'b1, AW'(i + 4), DW'(32'hD0 + i));
        tick();
        bus.req_valid = '0;
        tick();
        chk("midrst_ptr0", 64'(bus.Wt_addr), 64'(4));
        idle(4);

        // staged write r7 seen through read port B
        bus.R_addr_B = AW'(7);
        drive(WB_SRC_MDU, 1'b1, AW'(7), 32'h55);
        tick();
        bus.req_valid = '0;
        tick();
        chk("stg_ls", 64'(bus.L_S), 64'(1));
`ifdef REGS_WB_BYPASS_EN
        chk("byp_B_v", 64'(bus.byp_B_v), 64'(1));
        chk("byp_B_data", 64'(bus.byp_B_data), 64'(32'h55));
        chk("byp_pend_B", 64'(bus.pend_B), 64'(0));
`else
        chk("stg_pend_B", 64'(bus.pend_B), 64'(1));
`endif
        idle(3);

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < N; i++)
                drive(i, 1'(($urandom_range(0, 3)) != 0), AW'($urandom_range(0, 7)), DW'($urandom));
            bus.R_addr_A = AW'($urandom_range(0, 7));
            bus.R_addr_B = AW'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
